apb_fifo_slave: RTL and testbench
=================================

Name: apb_fifo_slave

Overview:
- Parametrised APB4 completer that fronts a synchronous FIFO with a small register map (DATA, STATUS, CTRL, THRESH).
- Adds programmable wait states, PSTRB byte strobes, PSLVERR error signalling and a level-threshold interrupt; none of these exist in the earlier APB bus bundle.
- Sits between the APB fabric and FIFO-consuming logic. It is the DUT for the UVM FIFO environment.

Parameters:
- ADDR_WIDTH, 8, PADDR width; must be ≥4.
- DATA_WIDTH, 32, PWDATA/PRDATA/FIFO word width; must be a multiple of 8 and ≥16.
- DEPTH, 16, FIFO entries; must be a power of 2 and ≥2.
- WAIT_STATES, 0, PREADY-low cycles inserted in every access phase; range 0..15.

Ports:
- PCLK  in  1  clock; all logic is on the rising edge.
- PRESETn  in  1  asynchronous, active-low reset.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB access-phase flag.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_WIDTH  byte address; only bits [3:2] are decoded, and upper bits must be 0.
- PWDATA  in  DATA_WIDTH  write data.
- PSTRB  in  DATA_WIDTH/8  write byte strobes.
- PRDATA  out  DATA_WIDTH  read data.
- PREADY  out  1  transfer completion.
- PSLVERR  out  1  transfer error; valid only while PREADY=1.
- irq  out  1  level interrupt.

Behaviour:
- Reset (PRESETn=0, asynchronous):
  - FIFO is emptied: rd/wr pointers and count go to 0.
  - CTRL=0, THRESH=0, wait counter=0, FSM=IDLE.
  - PRDATA=0, PREADY=0, PSLVERR=0, irq=0.
- FSM states are IDLE and ACCESS.
  - IDLE→ACCESS when PSEL=1 and PENABLE=0 (setup phase); the wait counter is loaded with WAIT_STATES.
  - In ACCESS, while the counter is nonzero: PREADY=0 and the counter decrements.
  - In ACCESS, when the counter is 0: PREADY=1 combinationally, and the transfer commits on that edge.
  - The FSM returns to IDLE on the commit edge.
  - Back-to-back transfers (a new setup on the next cycle) are supported with no idle gap.
- Abort: if PSEL drops while in ACCESS, the FSM returns to IDLE. There are no side effects and PREADY stays 0.
- Register map (PADDR[3:2]):
  - 0 DATA
    - Write pushes PWDATA. PSTRB must be all ones, otherwise PSLVERR is raised.
    - Read pops the FIFO head; PRDATA = head during the ready cycle.
  - 1 STATUS (read-only)
    - bit0 = empty, bit1 = full, bits[15:8] = count (zero-extended).
    - Writes are rejected with PSLVERR.
  - 2 CTRL
    - bit0 = flush: write-1 empties the FIFO in the commit cycle; it self-clears and reads as 0.
    - bit1 = irq_en.
    - The PSTRB[0] lane gates the write.
  - 3 THRESH
    - bits[7:0] = level, writable per PSTRB[0].
    - Read returns the value zero-extended.
- PSLVERR=1 on the ready cycle, with no state change, for any of:
  - write to DATA when full;
  - read of DATA when empty (PRDATA=0);
  - nonzero PADDR bits above [3:2], or PADDR[1:0]≠0;
  - write to STATUS;
  - partial PSTRB on a DATA write.
- PRDATA is 0 except during a ready read cycle.
- count width is $clog2(DEPTH+1).
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Simultaneous events cannot occur: APB is single-master, one transfer at a time. A flush issued while full clears full in the same cycle.
- irq is registered: irq = irq_en & (count ≥ THRESH) & (THRESH≠0). It updates one cycle after the count changes.
- Reset asserted mid-transfer aborts the transfer immediately. The master observes PREADY=0.

Test Plan:
- WAIT_STATES=0: write DATA 0xA5A5_0001, then read STATUS → PREADY high in the first access cycle, STATUS=0x0000_0100 (count 1, not empty). Read DATA → 0xA5A5_0001, then STATUS=0x1 (empty).
- DEPTH=16: push 0..15, push 16 → 16th push PSLVERR=0, 17th PSLVERR=1; STATUS=0x0000_1002. Pop 16 values → returns 0..15 in order, which exercises pointer wrap. Extra pop → PSLVERR=1, PRDATA=0.
- WAIT_STATES=3: any access → PREADY low for exactly 3 ACCESS cycles and high on the 4th. The setup-to-completion total is 5 cycles.
- THRESH=4, CTRL=0x2: push 4 words → irq rises the cycle after the 4th commit. Write CTRL=0x3 (flush) → count=0, irq falls the next cycle, CTRL reads 0x2.
- Error paths → PSLVERR=1 with no FIFO change for each of:
  - PADDR=0x10;
  - PADDR=0x02;
  - write STATUS;
  - DATA write with PSTRB=4'b0111.
- Abort and reset:
  - Drop PSEL during a WAIT_STATES=3 access → no push, FSM back in IDLE.
  - Assert PRESETn low mid-access with 5 entries stored → PREADY=0 and count=0 immediately, irq=0.

Source files
------------

// File: rtl/apb_fifo_slave.sv
// APB4 completer fronting a synchronous FIFO, with DATA/STATUS/CTRL/THRESH registers,
// programmable wait states, byte-strobe checks, PSLVERR signalling and a level interrupt.
//   state    | meaning
//   S_IDLE   | no transfer in flight; waiting for a setup phase
//   S_ACCESS | access phase; PREADY rises once the wait counter reaches 0
module apb_fifo_slave #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 16,
    parameter int WAIT_STATES = 0
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR,
    output logic                    irq
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic {S_IDLE, S_ACCESS} state_e;

    state_e                  state_q;
    logic [3:0]              wait_q;
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           count_q, count_d;
    logic                    irq_en_q;
    logic [7:0]              thresh_q;
    logic                    irq_q, irq_d;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic                    empty, full, addr_ok, access_done, err;
    logic                    commit_ok, do_push, do_pop, ctrl_wr, thresh_wr, flush;
    logic [1:0]              reg_sel;
    logic [DATA_WIDTH-1:0]   rdata;

    assign empty       = (count_q == '0);
    assign full        = (count_q == CW'(DEPTH));
    assign reg_sel     = PADDR[3:2];
    assign addr_ok     = (PADDR[1:0] == 2'b00) && ((PADDR >> 4) == '0);
    assign access_done = (state_q == S_ACCESS) && PSEL && (wait_q == 4'd0);

    always_comb begin
        err = 1'b0;
        if (!addr_ok) begin
            err = 1'b1;
        end else begin
            case (reg_sel)
                2'd0:    err = PWRITE ? (full || !(&PSTRB)) : empty;
                2'd1:    err = PWRITE;
                default: err = 1'b0;
            endcase
        end
    end

    assign commit_ok = access_done && !err;
    assign do_push   = commit_ok && PWRITE && (reg_sel == 2'd0);
    assign do_pop    = commit_ok && !PWRITE && (reg_sel == 2'd0);
    assign ctrl_wr   = commit_ok && PWRITE && (reg_sel == 2'd2) && PSTRB[0];
    assign thresh_wr = commit_ok && PWRITE && (reg_sel == 2'd3) && PSTRB[0];
    assign flush     = ctrl_wr && PWDATA[0];

    always_comb begin
        rdata = '0;
        case (reg_sel)
            2'd0: rdata = mem_q[rd_ptr_q];
            2'd1: begin
                rdata[0]    = empty;
                rdata[1]    = full;
                rdata[15:8] = 8'(count_q);
            end
            2'd2:    rdata[1]   = irq_en_q;
            default: rdata[7:0] = thresh_q;
        endcase
    end

    assign PREADY  = access_done;
    assign PSLVERR = access_done && err;
    assign PRDATA  = (access_done && !PWRITE && !err) ? rdata : '0;
    assign irq     = irq_q;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= S_IDLE;
            wait_q  <= 4'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (PSEL && !PENABLE) begin
                        state_q <= S_ACCESS;
                        wait_q  <= 4'(WAIT_STATES);
                    end
                end
                default: begin
                    // Dropping PSEL mid-access abandons the transfer without side effects.
                    if (!PSEL || wait_q == 4'd0) begin
                        state_q <= S_IDLE;
                    end else begin
                        wait_q <= wait_q - 4'd1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else if (do_push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            count_d  = count_q + CW'(1);
        end else if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            count_d  = count_q - CW'(1);
        end
    end

    // irq looks at the registered count, so it trails a count change by one cycle.
    assign irq_d = irq_en_q && (thresh_q != 8'd0) && (32'(count_q) >= 32'(thresh_q));

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            irq_en_q <= 1'b0;
            thresh_q <= 8'd0;
            irq_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            irq_q    <= irq_d;
            if (ctrl_wr)   irq_en_q <= PWDATA[1];
            if (thresh_wr) thresh_q <= PWDATA[7:0];
        end
    end

    always_ff @(posedge PCLK) begin
        if (do_push) mem_q[wr_ptr_q] <= PWDATA;
    end

endmodule

// File: tb/tb_apb_fifo_slave.sv
// Self-checking bench for apb_fifo_slave: one zero-wait instance and one three-wait instance
// sharing the APB bus, with directed scenarios plus a randomized run against a queue model.
module tb_apb_fifo_slave;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [7:0]  paddr = 8'h0;
    logic [31:0] pwdata = 32'h0;
    logic [3:0]  pstrb = 4'h0;
    bit          sel3 = 1'b0;

    logic        psel0, psel3;
    logic [31:0] prdata0, prdata3, prdata;
    logic        pready0, pready3, pready;
    logic        pslverr0, pslverr3, pslverr;
    logic        irq0, irq3, irq;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    logic [31:0] mq[$];
    bit          m_irq_en;
    logic [7:0]  m_thr;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    assign psel0   = psel & !sel3;
    assign psel3   = psel & sel3;
    assign prdata  = sel3 ? prdata3  : prdata0;
    assign pready  = sel3 ? pready3  : pready0;
    assign pslverr = sel3 ? pslverr3 : pslverr0;
    assign irq     = sel3 ? irq3     : irq0;

    apb_fifo_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(16), .WAIT_STATES(0)) dut0 (
        .PCLK(clk), .PRESETn(rst_n), .PSEL(psel0), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(prdata0), .PREADY(pready0),
        .PSLVERR(pslverr0), .irq(irq0));

    apb_fifo_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(16), .WAIT_STATES(3)) dut3 (
        .PCLK(clk), .PRESETn(rst_n), .PSEL(psel3), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(prdata3), .PREADY(pready3),
        .PSLVERR(pslverr3), .irq(irq3));

    // Starts right after a clock edge and returns #1 after the commit edge, so calls
    // made one after another form back-to-back transfers.
    task automatic apb(input bit w, input logic [7:0] a, input logic [31:0] wd,
                       input logic [3:0] st, output logic [31:0] rd, output logic er,
                       output int waits);
        psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = wd; pstrb = st;
        @(posedge clk); #1;
        penable = 1'b1;
        waits = 0;
        while (!pready && waits < 40) begin
            @(posedge clk); #1;
            waits++;
        end
        if (!pready) begin
            tests++; fails++;
            $display("FAIL apb_timeout addr=%h got PREADY=%b required 1", a, pready);
        end
        rd = prdata;
        er = pslverr;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic do_reset();
        psel = 1'b0; penable = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        mq.delete();
        m_irq_en = 1'b0;
        m_thr = 8'h0;
    endtask

    task automatic model_op(input bit w, input logic [7:0] a, input logic [31:0] wd,
                            input logic [3:0] st, output logic [31:0] erd, output logic eer);
        erd = 32'h0; eer = 1'b0;
        if (a[1:0] != 2'b00 || a[7:4] != 4'h0) begin
            eer = 1'b1;
        end else begin
            case (a[3:2])
                2'd0: begin
                    if (w) begin
                        if (mq.size() == 16 || st != 4'hF) eer = 1'b1;
                        else mq.push_back(wd);
                    end else begin
                        if (mq.size() == 0) eer = 1'b1;
                        else erd = mq.pop_front();
                    end
                end
                2'd1: begin
                    if (w) eer = 1'b1;
                    else erd = {16'h0, 8'(mq.size()), 6'h0, mq.size() == 16, mq.size() == 0};
                end
                2'd2: begin
                    if (w) begin
                        if (st[0]) begin
                            m_irq_en = wd[1];
                            if (wd[0]) mq.delete();
                        end
                    end else erd = {30'h0, m_irq_en, 1'b0};
                end
                default: begin
                    if (w) begin
                        if (st[0]) m_thr = wd[7:0];
                    end else erd = {24'h0, m_thr};
                end
            endcase
        end
    endtask

    function automatic bit model_irq();
        return m_irq_en && (m_thr != 8'h0) && (mq.size() >= int'(m_thr));
    endfunction

    task automatic test_reset();
        logic [31:0] rd; logic er; int wt;
        sel3 = 1'b0;
        psel = 1'b0; penable = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({pready0, pready3, pslverr0, pslverr3, irq0, irq3} !== 6'b0 || prdata0 !== 32'h0 || prdata3 !== 32'h0) begin
            fails++;
            $display("FAIL reset_outputs got rdy=%b%b err=%b%b irq=%b%b rd=%h/%h required all 0",
                     pready0, pready3, pslverr0, pslverr3, irq0, irq3, prdata0, prdata3);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        apb(1'b0, 8'h04, 32'h0, 4'h0, rd, er, wt);
        tests++;
        if (rd !== 32'h1 || er !== 1'b0) begin
            fails++; $display("FAIL reset_status got %h err=%b required 00000001 err=0", rd, er);
        end
        apb(1'b0, 8'h08, 32'h0, 4'h0, rd, er, wt);
        tests++;
        if (rd !== 32'h0) begin fails++; $display("FAIL reset_ctrl got %h required 0", rd); end
        apb(1'b0, 8'h0C, 32'h0, 4'h0, rd, er, wt);
        tests++;
        if (rd !== 32'h0) begin fails++; $display("FAIL reset_thresh got %h required 0", rd); end
    endtask

    task automatic test_basic();
        logic [31:0] rd; logic er; int wt;
        sel3 = 1'b0; do_reset();
        apb(1'b1, 8'h00, 32'hA5A5_0001, 4'hF, rd, er, wt);
        tests++;
        if (er !== 1'b0 || wt != 0) begin
            fails++; $display("FAIL basic_push got err=%b waits=%0d required err=0 waits=0", er, wt);
        end
        apb(1'b0, 8'h04, 32'h0, 4'h0, rd, er, wt);
        tests++;
        if (rd !== 32'h0000_0100 || wt != 0) begin
            fails++; $display("FAIL basic_status1 got %h waits=%0d required 00000100 waits=0", rd, wt);
        end
        apb(1'b0, 8'h00, 32'h0, 4'h0, rd, er, wt);
        tests++;
        if (rd !== 32'hA5A5_0001 || er !== 1'b0) begin
            fails++; $display("FAIL basic_pop got %h err=%b required a5a50001 err=0", rd, er);
        end
        apb(1'b0, 8'h04, 32'h0, 4'h0, rd, er, wt);
        tests++;
        if (rd !== 32'h1) begin fails++; $display("FAIL basic_status2 got %h required 00000001", rd); end
    endtask

    task automatic test_fill_wrap();
        logic [31:0] rd; logic er; int wt;
        sel3 = 1'b0; do_reset();
        for (int i = 0; i < 16; i++) begin
            apb(1'b1, 8'h00, 32'(i), 4'hF, rd, er, wt);
            tests++;
            if (er !== 1'b0) begin fails++; $display("FAIL fill_push%0d got err=%b required 0", i, er); end
        end
        apb(1'b1, 8'h00, 32'd16, 4'hF, rd, er, wt);
        tests++;
        if (er !== 1'b1) begin fails++; $display("FAIL fill_overflow got err=%b required 1", er); end
        apb(1'b0, 8'h04, 32'h0, 4'h0, rd, er, wt);
        tests++;
        if (rd !== 32'h0000_1002) begin fails++; $display("FAIL fill_status got %h required 00001002", rd); end
        for (int i = 0; i < 16; i++) begin
            apb(1'b0, 8'h00, 32'h0, 4'h0, rd, er, wt);
            tests++;
            if (rd !== 32'(i) || er !== 1'b0) begin
                fails++; $display("FAIL fill_pop%0d got %h err=%b required %h err=0", i, rd, er, 32'(i));
            end
        end
        apb(1'b0, 8'h00, 32'h0, 4'h0, rd, er, wt);
        tests++;
        if (rd !== 32'h0 || er !== 1'b1) begin
            fails++; $display("FAIL fill_underflow got %h err=%b required 0 err=1", rd, er);
        end
    endtask

    task automatic test_irq_flush();
        logic [31:0] rd; logic er; int wt;
        sel3 = 1'b0; do_reset();
        apb(1'b1, 8'h0C, 32'h4, 4'hF, rd, er, wt);
        apb(1'b1, 8'h08, 32'h2, 4'hF, rd, er, wt);
        for (int i = 0; i < 4; i++) apb(1'b1, 8'h00, 32'h100 + 32'(i), 4'hF, rd, er, wt);
        tests++;
        if (irq !== 1'b0) begin fails++; $display("FAIL irq_early got %b required 0", irq); end
        @(posedge clk); #1;
        tests++;
        if (irq !== 1'b1) begin fails++; $display("FAIL irq_rise got %b required 1", irq); end
        apb(1'b1, 8'h08, 32'h3, 4'hF, rd, er, wt);
        tests++;
        if (irq !== 1'b1) begin fails++; $display("FAIL irq_flush_hold got %b required 1", irq); end
        @(posedge clk); #1;
        tests++;
        if (irq !== 1'b0) begin fails++; $display("FAIL irq_fall got %b required 0", irq); end
        apb(1'b0, 8'h08, 32'h0, 4'h0, rd, er, wt);
        tests++;
        if (rd !== 32'h2) begin fails++; $display("FAIL ctrl_read got %h required 00000002", rd); end
        apb(1'b0, 8'h04, 32'h0, 4'h0, rd, er, wt);
        tests++;
        if (rd !== 32'h1) begin fails++; $display("FAIL flush_status got %h required 00000001", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int wt;
        sel3 = 1'b0; do_reset();
        apb(1'b1, 8'h00, 32'h11, 4'hF, rd, er, wt);
        apb(1'b1, 8'h00, 32'h22, 4'hF, rd, er, wt);
        apb(1'b0, 8'h10, 32'h0, 4'h0, rd, er, wt);
        tests++;
        if (er !== 1'b1) begin fails++; $display("FAIL err_addr10 got %b required 1", er); end
        apb(1'b1, 8'h02, 32'h33, 4'hF, rd, er, wt);
        tests++;
        if (er !== 1'b1) begin fails++; $display("FAIL err_addr02 got %b required 1", er); end
        apb(1'b1, 8'h40, 32'h44, 4'hF, rd, er, wt);
        tests++;
        if (er !== 1'b1) begin fails++; $display("FAIL err_addr40 got %b required 1", er); end
        apb(1'b1, 8'h04, 32'h55, 4'hF, rd, er, wt);
        tests++;
        if (er !== 1'b1) begin fails++; $display("FAIL err_status_wr got %b required 1", er); end
        apb(1'b1, 8'h00, 32'h66, 4'h7, rd, er, wt);
        tests++;
        if (er !== 1'b1) begin fails++; $display("FAIL err_strb got %b required 1", er); end
        apb(1'b0, 8'h04, 32'h0, 4'h0, rd, er, wt);
        tests++;
        if (rd !== 32'h0000_0200 || er !== 1'b0) begin
            fails++; $display("FAIL err_status got %h err=%b required 00000200 err=0", rd, er);
        end
        apb(1'b0, 8'h00, 32'h0, 4'h0, rd, er, wt);
        tests++;
        if (rd !== 32'h11) begin fails++; $display("FAIL err_head got %h required 00000011", rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic er; int wt; int c0;
        sel3 = 1'b0; do_reset();
        c0 = cyc;
        apb(1'b1, 8'h00, 32'hB0B0_0001, 4'hF, rd, er, wt);
        apb(1'b1, 8'h00, 32'hB0B0_0002, 4'hF, rd, er, wt);
        apb(1'b0, 8'h00, 32'h0, 4'h0, rd, er, wt);
        tests++;
        if (rd !== 32'hB0B0_0001) begin fails++; $display("FAIL b2b_pop1 got %h required b0b00001", rd); end
        apb(1'b0, 8'h00, 32'h0, 4'h0, rd, er, wt);
        tests++;
        if (rd !== 32'hB0B0_0002) begin fails++; $display("FAIL b2b_pop2 got %h required b0b00002", rd); end
        tests++;
        if (cyc - c0 != 8) begin fails++; $display("FAIL b2b_cycles got %0d required 8", cyc - c0); end
    endtask

    task automatic test_wait_abort();
        logic [31:0] rd; logic er; int wt; int c0;
        sel3 = 1'b1; do_reset();
        c0 = cyc;
        apb(1'b0, 8'h04, 32'h0, 4'h0, rd, er, wt);
        tests++;
        if (wt != 3 || cyc - c0 != 5 || rd !== 32'h1) begin
            fails++; $display("FAIL wait_timing got waits=%0d cycles=%0d rd=%h required 3/5/00000001", wt, cyc - c0, rd);
        end
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 32'hDEAD_BEEF; pstrb = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tests++;
            if (pready !== 1'b0) begin fails++; $display("FAIL abort_wait%0d got PREADY=%b required 0", i, pready); end
            @(posedge clk); #1;
        end
        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (pready !== 1'b0) begin fails++; $display("FAIL abort_ready got %b required 0", pready); end
        apb(1'b0, 8'h04, 32'h0, 4'h0, rd, er, wt);
        tests++;
        if (rd !== 32'h1 || wt != 3) begin
            fails++; $display("FAIL abort_nopush got %h waits=%0d required 00000001 waits=3", rd, wt);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er; int wt;
        sel3 = 1'b1; do_reset();
        apb(1'b1, 8'h0C, 32'h2, 4'hF, rd, er, wt);
        apb(1'b1, 8'h08, 32'h2, 4'hF, rd, er, wt);
        for (int i = 0; i < 5; i++) apb(1'b1, 8'h00, 32'hC0 + 32'(i), 4'hF, rd, er, wt);
        @(posedge clk); #1;
        tests++;
        if (irq !== 1'b1) begin fails++; $display("FAIL rstmid_irq_pre got %b required 1", irq); end
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h00;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        tests++;
        if (pready !== 1'b0 || irq !== 1'b0 || prdata !== 32'h0) begin
            fails++; $display("FAIL rstmid_outputs got rdy=%b irq=%b rd=%h required 0/0/0", pready, irq, prdata);
        end
        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        apb(1'b0, 8'h04, 32'h0, 4'h0, rd, er, wt);
        tests++;
        if (rd !== 32'h1) begin fails++; $display("FAIL rstmid_status got %h required 00000001", rd); end
    endtask

    task automatic test_random();
        logic [31:0] rd, erd, wd; logic er, eer; int wt; bit w; logic [7:0] a; logic [3:0] st;
        logic [7:0] bad_addrs [4];
        bad_addrs[0] = 8'h10; bad_addrs[1] = 8'h02; bad_addrs[2] = 8'h41; bad_addrs[3] = 8'h83;
        sel3 = 1'b0; do_reset();
        for (int n = 0; n < 300; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 8) a = bad_addrs[$urandom_range(0, 3)];
            else if (r < 60) a = 8'h00;
            else a = {4'h0, 2'($urandom_range(1, 3)), 2'b00};
            w = ($urandom_range(0, 99) < 55);
            wd = $urandom;
            if (a == 8'h08) wd[0] = ($urandom_range(0, 9) == 0);
            if (a == 8'h0C) wd[7:0] = 8'($urandom_range(0, 18));
            st = ($urandom_range(0, 99) < 85) ? 4'hF : 4'($urandom_range(0, 15));
            apb(w, a, wd, st, rd, er, wt);
            model_op(w, a, wd, st, erd, eer);
            tests++;
            if (er !== eer) begin
                fails++; $display("FAIL rand_err op=%0d addr=%h w=%0b got %b required %b", n, a, w, er, eer);
            end
            if (!eer || (a == 8'h00 && !w)) begin
                tests++;
                if (rd !== erd) begin
                    fails++; $display("FAIL rand_rdata op=%0d addr=%h w=%0b got %h required %h", n, a, w, rd, erd);
                end
            end
            @(posedge clk); #1;
            tests++;
            if (irq !== model_irq()) begin
                fails++; $display("FAIL rand_irq op=%0d got %b required %b", n, irq, model_irq());
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill_wrap();
        test_irq_flush();
        test_errors();
        test_back_to_back();
        test_wait_abort();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
